// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, ALU operation
// encoding, sequencer state encoding and small key-to-operation helpers.
package calc_pkg;

    // Key codes (bits [3:0] of a valid key pulse); 0-9 are digits.
    localparam logic [3:0] KEY_DIV = 4'ha;  // "/%" key
    localparam logic [3:0] KEY_MUL = 4'hb;  // "*" key
    localparam logic [3:0] KEY_ADD = 4'hc;  // "+-" key
    localparam logic [3:0] KEY_AC  = 4'hd;  // all clear
    localparam logic [3:0] KEY_ANS = 4'he;  // recall last good result
    localparam logic [3:0] KEY_EQ  = 4'hf;  // start the calculation

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpDiv = 3'd3,
        OpMod = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        StA   = 3'd0,
        StOp  = 3'd1,
        StB   = 3'd2,
        StReq = 3'd3,
        StRes = 3'd4,
        StErr = 3'd5
    } state_e;

    // Operation selected by a fresh press of an operator key.
    function automatic op_e key_to_op(logic [3:0] key);
        case (key)
            KEY_DIV: return OpDiv;
            KEY_MUL: return OpMul;
            default: return OpAdd;
        endcase
    endfunction

    // Operator key pressed while an operation is already pending: the same
    // key flips between its two meanings, another key replaces the op.
    function automatic op_e toggle_op(op_e cur, logic [3:0] key);
        if (key == KEY_ADD && cur == OpAdd) return OpSub;
        if (key == KEY_ADD && cur == OpSub) return OpAdd;
        if (key == KEY_DIV && cur == OpDiv) return OpMod;
        if (key == KEY_DIV && cur == OpMod) return OpDiv;
        return key_to_op(key);
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// ALU request/acknowledge bus between the calculator sequencer and the ALU.
//   master (sequencer): drives alu_req, alu_op, alu_a, alu_b;
//                       receives alu_ack, alu_result, alu_err.
//   slave  (ALU)      : the mirror image.
interface calc_seq_ctrl_if
    import calc_pkg::*;
#(
    parameter int unsigned W = 32
);
    logic         alu_req;
    op_e          alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_ack;
    logic [W-1:0] alu_result;
    logic         alu_err;

    modport master (
        output alu_req, alu_op, alu_a, alu_b,
        input  alu_ack, alu_result, alu_err
    );

    modport slave (
        input  alu_req, alu_op, alu_a, alu_b,
        output alu_ack, alu_result, alu_err
    );
endinterface

// File: rtl/calc_operand_reg.sv
// Decimal operand accumulator with digit count and lock.
//   clk, rst     : clock, asynchronous active-high reset
//   clear_i      : discard current value/count (may combine with digit_en_i
//                  to restart the operand with a single digit)
//   load_i       : load load_val_i and lock out further digits (wins)
//   load_val_i   : value to load
//   digit_en_i   : accumulate digit_i as val*10 + digit (dropped when full)
//   digit_i      : decimal digit 0-9
//   val_o        : current operand value
//   empty_o      : no digits entered and nothing loaded
module calc_operand_reg #(
    parameter int unsigned W      = 32,
    parameter int unsigned DIGITS = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         digit_en_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] val_o,
    output logic         empty_o
);
    localparam int unsigned CntW = $clog2(DIGITS + 1);

    logic [W-1:0]    val_q, val_d, base_val;
    logic [CntW-1:0] cnt_q, cnt_d, base_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        base_val = clear_i ? '0 : val_q;
        base_cnt = clear_i ? '0 : cnt_q;
        val_d    = base_val;
        cnt_d    = base_cnt;
        if (load_i) begin
            val_d = load_val_i;
            cnt_d = CntW'(DIGITS);
        end else if (digit_en_i && base_cnt < CntW'(DIGITS)) begin
            // val*10 as shift-add; cannot overflow for DIGITS decimal digits.
            val_d = (base_val << 3) + (base_val << 1) + W'(digit_i);
            cnt_d = base_cnt + 1'b1;
        end
    end

    assign val_o   = val_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: turns keypad key pulses into operand A, operator and
// operand B, issues one request to a shared multi-cycle ALU and keeps the
// result for display and for the "ans" key.
//   clk, rst     : clock, asynchronous active-high reset
//   key_code_i   : 1-cycle key pulse, bit4 = valid, bits[3:0] = key
//   alu_io       : ALU req/ack bus (master side)
//   disp_value_o : value to show (A, B, result or 0 depending on state)
//   err_o        : ALU reported an error (or timed out); only AC leaves
//   busy_o       : ALU request outstanding
// Optional: define CALC_ALU_TIMEOUT_EN to abandon a request after TIMEOUT
// cycles without ack and go to the error state.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned DIGITS  = 9,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          key_code_i,
    calc_seq_ctrl_if.master     alu_io,
    output logic [W-1:0]        disp_value_o,
    output logic                err_o,
    output logic                busy_o
);
    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] ans_q, ans_d;
    logic         abort_q, abort_d;
    logic         req_q, req_d;
`ifdef CALC_ALU_TIMEOUT_EN
    logic [31:0]  tmo_q, tmo_d;
`endif

    logic         a_clear, a_load, a_digit, b_clear, b_load, b_digit;
    logic [W-1:0] a_load_val, a_val, b_val;
    logic         a_empty, b_empty;

    logic [3:0] key;
    logic       key_vld, is_digit, is_op, is_ac, is_ans, is_eq, ack;

    assign key      = key_code_i[3:0];
    assign key_vld  = key_code_i[4];
    assign is_digit = key_vld && (key <= 4'd9);
    assign is_op    = key_vld && (key == KEY_DIV || key == KEY_MUL || key == KEY_ADD);
    assign is_ac    = key_vld && (key == KEY_AC);
    assign is_ans   = key_vld && (key == KEY_ANS);
    assign is_eq    = key_vld && (key == KEY_EQ);
    // A late ack with no request outstanding is ignored.
    assign ack      = alu_io.alu_ack && req_q;

    calc_operand_reg #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_opnd_a (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (a_clear),
        .load_i     (a_load),
        .load_val_i (a_load_val),
        .digit_en_i (a_digit),
        .digit_i    (key),
        .val_o      (a_val),
        .empty_o    (a_empty)
    );

    calc_operand_reg #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_opnd_b (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (b_clear),
        .load_i     (b_load),
        .load_val_i (ans_q),
        .digit_en_i (b_digit),
        .digit_i    (key),
        .val_o      (b_val),
        .empty_o    (b_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StA;
            op_q    <= OpAdd;
            res_q   <= '0;
            ans_q   <= '0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ans_q   <= ans_d;
            abort_q <= abort_d;
            req_q   <= req_d;
`ifdef CALC_ALU_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        res_d      = res_q;
        ans_d      = ans_q;
        abort_d    = abort_q;
        req_d      = req_q;
        a_clear    = 1'b0;
        a_load     = 1'b0;
        a_load_val = ans_q;
        a_digit    = 1'b0;
        b_clear    = 1'b0;
        b_load     = 1'b0;
        b_digit    = 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
        tmo_d      = '0;
`endif
        if (is_ac && state_q != StReq) begin
            a_clear = 1'b1;
            b_clear = 1'b1;
            res_d   = '0;
            op_d    = OpAdd;
            state_d = StA;
        end else begin
            case (state_q)
                StA: begin
                    if (is_digit) begin
                        a_digit = 1'b1;
                    end else if (is_op) begin
                        op_d    = key_to_op(key);
                        state_d = StOp;
                    end else if (is_ans && a_empty) begin
                        a_load = 1'b1;
                    end
                end
                StOp: begin
                    if (is_op) begin
                        op_d = toggle_op(op_q, key);
                    end else if (is_digit) begin
                        b_clear = 1'b1;
                        b_digit = 1'b1;
                        state_d = StB;
                    end else if (is_ans) begin
                        b_load  = 1'b1;
                        state_d = StB;
                    end
                end
                StB: begin
                    if (is_digit) begin
                        b_digit = 1'b1;
                    end else if (is_eq) begin
                        req_d   = 1'b1;
                        state_d = StReq;
                    end
                end
                StReq: begin
                    if (is_ac) abort_d = 1'b1;
                    if (ack) begin
                        req_d   = 1'b0;
                        abort_d = 1'b0;
                        if (abort_q || is_ac) begin
                            // Aborted: drop the result and clear everything.
                            a_clear = 1'b1;
                            b_clear = 1'b1;
                            res_d   = '0;
                            op_d    = OpAdd;
                            state_d = StA;
                        end else if (alu_io.alu_err) begin
                            state_d = StErr;
                        end else begin
                            res_d   = alu_io.alu_result;
                            ans_d   = alu_io.alu_result;
                            state_d = StRes;
                        end
                    end
`ifdef CALC_ALU_TIMEOUT_EN
                    else if (tmo_q == 32'(TIMEOUT - 1)) begin
                        req_d   = 1'b0;
                        abort_d = 1'b0;
                        state_d = StErr;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
`endif
                end
                StRes: begin
                    if (is_digit) begin
                        a_clear = 1'b1;
                        a_digit = 1'b1;
                        state_d = StA;
                    end else if (is_op) begin
                        // Chain: the previous result becomes operand A.
                        a_load     = 1'b1;
                        a_load_val = res_q;
                        op_d       = key_to_op(key);
                        state_d    = StOp;
                    end else if (is_ans) begin
                        a_load  = 1'b1;
                        state_d = StA;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        alu_io.alu_req = req_q;
        alu_io.alu_op  = op_q;
        alu_io.alu_a   = a_val;
        alu_io.alu_b   = b_val;
        err_o          = (state_q == StErr);
        busy_o         = (state_q == StReq);
        case (state_q)
            StA, StOp:    disp_value_o = a_val;
            StB:          disp_value_o = b_val;
            StReq, StRes: disp_value_o = res_q;
            default:      disp_value_o = '0;
        endcase
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
module tb_calc_seq_ctrl;
    import calc_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  key_code;
    logic [31:0] disp_value;
    logic        err;
    logic        busy;

    calc_seq_ctrl_if #(.W(32)) alu_if ();

    calc_seq_ctrl #(
        .W       (32),
        .DIGITS  (9),
        .TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_code_i   (key_code),
        .alu_io       (alu_if),
        .disp_value_o (disp_value),
        .err_o        (err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key applied at a negedge, sampled by the next posedge, removed at the
    // following negedge, where the effect is observed.
    task automatic press(input logic [3:0] k);
        key_code = {1'b1, k};
        @(negedge clk);
        key_code = 5'd0;
    endtask

    task automatic expect_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.op = op;
        e.a  = a;
        e.b  = b;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a request, then check it against the scoreboard.
    task automatic wait_req(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!alu_if.alu_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(alu_if.alu_req), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_op"}, 32'(alu_if.alu_op), 32'(e.op));
            chk({tag, "_a"}, alu_if.alu_a, e.a);
            chk({tag, "_b"}, alu_if.alu_b, e.b);
        end
    endtask

    task automatic do_ack(input string tag, input logic [31:0] res, input logic e);
        alu_if.alu_ack    = 1'b1;
        alu_if.alu_result = res;
        alu_if.alu_err    = e;
        @(negedge clk);
        alu_if.alu_ack    = 1'b0;
        alu_if.alu_result = 32'hdead_beef;
        alu_if.alu_err    = 1'b0;
        chk({tag, "_req_drop"}, 32'(alu_if.alu_req), 32'd0);
    endtask

    initial begin
        int hi_cnt;
        rst               = 1'b1;
        key_code          = 5'd0;
        alu_if.alu_ack    = 1'b0;
        alu_if.alu_result = '0;
        alu_if.alu_err    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req", 32'(alu_if.alu_req), 32'd0);
        chk("rst_op", 32'(alu_if.alu_op), 32'd0);
        chk("rst_a", alu_if.alu_a, 32'd0);
        chk("rst_b", alu_if.alu_b, 32'd0);
        chk("rst_disp", disp_value, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // "=" in S_A is ignored; valid-low codes are no-ops
        press(KEY_EQ);
        chk("eq_in_a", 32'(busy), 32'd0);
        key_code = 5'h07;
        @(negedge clk);
        key_code = 5'd0;
        chk("novalid", disp_value, 32'd0);

        // 12 + 3 = 15, ack two cycles after req
        press(4'd1);
        press(4'd2);
        chk("t1_disp_a", disp_value, 32'd12);
        press(KEY_ADD);
        chk("t1_disp_op", disp_value, 32'd12);
        press(4'd3);
        chk("t1_disp_b", disp_value, 32'd3);
        expect_txn(3'd0, 32'd12, 32'd3);
        press(KEY_EQ);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_req("t1");
        @(negedge clk);
        chk("t1_req_hold", 32'(alu_if.alu_req), 32'd1);
        do_ack("t1", 32'd15, 1'b0);
        chk("t1_res", disp_value, 32'd15);
        chk("t1_busy_end", 32'(busy), 32'd0);
        press(KEY_ANS);
        chk("t1_ans", disp_value, 32'd15);
        press(4'd4);
        chk("t1_ans_lock", disp_value, 32'd15);
        press(KEY_AC);
        chk("t1_ac", disp_value, 32'd0);

        // 7 - 9 = -2
        press(4'd7);
        press(KEY_ADD);
        press(KEY_ADD);
        press(4'd9);
        expect_txn(3'd1, 32'd7, 32'd9);
        press(KEY_EQ);
        wait_req("t2");
        do_ack("t2", 32'hffff_fffe, 1'b0);
        chk("t2_res", disp_value, 32'hffff_fffe);
        press(KEY_AC);

        // 8 % 0 -> ALU error
        press(4'd8);
        press(KEY_DIV);
        press(KEY_DIV);
        press(4'd0);
        expect_txn(3'd4, 32'd8, 32'd0);
        press(KEY_EQ);
        wait_req("t3");
        do_ack("t3", 32'd77, 1'b1);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_disp", disp_value, 32'd0);
        press(4'd5);
        chk("t3_digit_ign", 32'(err), 32'd1);
        press(KEY_ANS);
        chk("t3_ans_ign", disp_value, 32'd0);
        press(KEY_AC);
        chk("t3_ac_err", 32'(err), 32'd0);
        chk("t3_ac_disp", disp_value, 32'd0);

        // Ten 9s: the tenth is dropped; then "*" and ans (= -2 from before)
        for (int i = 0; i < 10; i++) press(4'd9);
        chk("t4_digits", disp_value, 32'd999_999_999);
        press(KEY_MUL);
        press(KEY_ADD);
        press(KEY_MUL);
        chk("t4_op_disp", disp_value, 32'd999_999_999);
        press(KEY_ANS);
        chk("t4_b_ans", disp_value, 32'hffff_fffe);
        press(4'd3);
        chk("t4_b_lock", disp_value, 32'hffff_fffe);
        expect_txn(3'd2, 32'd999_999_999, 32'hffff_fffe);
        press(KEY_EQ);
        wait_req("t4");
        do_ack("t4", 32'd15, 1'b0);
        chk("t4_res", disp_value, 32'd15);

        // Chain 15 * 2, then AC during the request
        press(KEY_EQ);
        chk("t5_eq_ign", disp_value, 32'd15);
        press(KEY_MUL);
        chk("t5_chain_a", disp_value, 32'd15);
        press(4'd2);
        expect_txn(3'd2, 32'd15, 32'd2);
        press(KEY_EQ);
        wait_req("t5");
        press(KEY_AC);
        chk("t5_ac_busy", 32'(busy), 32'd1);
        chk("t5_ac_req", 32'(alu_if.alu_req), 32'd1);
        do_ack("t5", 32'd30, 1'b0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_disp", disp_value, 32'd0);
        chk("t5_abort_op", 32'(alu_if.alu_op), 32'd0);
        press(KEY_ANS);
        chk("t5_ans_kept", disp_value, 32'd15);
        press(KEY_AC);

        // Late ack with nothing outstanding is ignored
        alu_if.alu_ack    = 1'b1;
        alu_if.alu_result = 32'd99;
        @(negedge clk);
        alu_if.alu_ack    = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_disp", disp_value, 32'd0);

`ifdef CALC_ALU_TIMEOUT_EN
        // No ack: request abandoned after TIMEOUT cycles
        press(4'd1);
        press(KEY_ADD);
        press(4'd1);
        expect_txn(3'd0, 32'd1, 32'd1);
        press(KEY_EQ);
        wait_req("t6");
        hi_cnt = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!alu_if.alu_req) break;
            hi_cnt++;
        end
        chk("t6_req_cycles", 32'(hi_cnt), 32'd255);
        chk("t6_err", 32'(err), 32'd1);
        alu_if.alu_ack    = 1'b1;
        alu_if.alu_result = 32'd1234;
        @(negedge clk);
        alu_if.alu_ack    = 1'b0;
        chk("t6_late_err", 32'(err), 32'd1);
        chk("t6_late_disp", disp_value, 32'd0);
        press(KEY_AC);
        chk("t6_ac", 32'(err), 32'd0);
`else
        hi_cnt = 0;
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
